// File: rtl/cache_sim_pkg.sv
// Shared types and default widths for the cache simulation blocks.
package cache_sim_pkg;

    localparam int CACHE_ADDR_W = 32;
    localparam int STAT_CNT_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        FINISH
    } drv_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear wins over increment, value sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/cache_trace_driver.sv
// Plays a trace from an external synchronous ROM into a cache under test and
// gathers saturating reference/hit/miss/cycle statistics.
module cache_trace_driver
    import cache_sim_pkg::*;
#(
    parameter int ADDR_W = CACHE_ADDR_W,
    parameter int IDX_W  = 16,
    parameter int CNT_W  = STAT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W:0]    trace_len,
    output logic [IDX_W-1:0]  mem_idx,
    input  logic [ADDR_W-1:0] mem_data,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic              rsp_hit,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  ref_count,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  cycle_count
);

    drv_state_t        state_reg, state_next;
    logic [IDX_W:0]    index_reg, index_next;
    logic [IDX_W:0]    len_reg, len_next;
    logic [IDX_W:0]    idx_inc;
    logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
    logic              req_valid_reg, req_valid_next;
    logic              err_reg, err_next;
    logic              start_ok;
    logic              rsp_take;
    logic [3:0]        cnt_inc;
    logic [CNT_W-1:0]  cnt_q [4];

    assign idx_inc = index_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            len_reg       <= '0;
            req_addr_reg  <= '0;
            req_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            len_reg       <= len_next;
            req_addr_reg  <= req_addr_next;
            req_valid_reg <= req_valid_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        len_next       = len_reg;
        req_addr_next  = req_addr_reg;
        req_valid_next = req_valid_reg;
        start_ok       = 1'b0;
        rsp_take       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    len_next   = trace_len;
                    index_next = '0;
                    state_next = (trace_len == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                req_addr_next  = mem_data;
                req_valid_next = 1'b1;
                state_next     = ISSUE;
            end
            ISSUE: begin
                if (req_ready) begin
                    req_valid_next = 1'b0;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    rsp_take = 1'b1;
                    if (idx_inc == len_reg) begin
                        state_next = FINISH;
                    end else begin
                        index_next = idx_inc;
                        state_next = FETCH;
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A response outside WAIT (including the handshake cycle itself) is a protocol error.
    always_comb begin
        err_next = err_reg;
        if (start_ok) begin
            err_next = 1'b0;
        end
        if (rsp_valid && (state_reg != WAIT)) begin
            err_next = 1'b1;
        end
    end

    // The ROM has one cycle of latency, so the index is presented a cycle before FETCH.
    always_comb begin
        case (state_reg)
            IDLE:    mem_idx = '0;
            WAIT:    mem_idx = idx_inc[IDX_W-1:0];
            default: mem_idx = index_reg[IDX_W-1:0];
        endcase
    end

    assign cnt_inc = {busy, rsp_take & ~rsp_hit, rsp_take & rsp_hit, rsp_take};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (start_ok),
                .inc   (cnt_inc[gi]),
                .q     (cnt_q[gi])
            );
        end
    endgenerate

    assign ref_count   = cnt_q[0];
    assign hit_count   = cnt_q[1];
    assign miss_count  = cnt_q[2];
    assign cycle_count = cnt_q[3];

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FINISH);
    assign err       = err_reg;
    assign req_valid = req_valid_reg;
    assign req_addr  = req_addr_reg;

endmodule

// File: tb/tb_cache_trace_driver.sv
// Directed bench: a wide-counter and a 4-bit-counter driver run in lockstep on one trace ROM.
module tb_cache_trace_driver;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [IDX_W:0]    trace_len;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [ADDR_W-1:0] rom [32];
    logic [ADDR_W-1:0] mem_data_a, mem_data_b;

    logic [IDX_W-1:0]  a_mem_idx, b_mem_idx;
    logic              a_req_valid, b_req_valid;
    logic [ADDR_W-1:0] a_req_addr, b_req_addr;
    logic              a_busy, a_done, a_err, b_busy, b_done, b_err;
    logic [31:0]       a_ref, a_hit, a_miss, a_cyc;
    logic [3:0]        b_ref, b_hit, b_miss, b_cyc;

    int errors = 0;
    int checks = 0;
    int res_dones, res_bdones, res_done_at;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data_a <= rom[a_mem_idx];
        mem_data_b <= rom[b_mem_idx];
    end

    cache_trace_driver #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .trace_len(trace_len),
        .mem_idx(a_mem_idx), .mem_data(mem_data_a),
        .req_valid(a_req_valid), .req_addr(a_req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .busy(a_busy), .done(a_done), .err(a_err),
        .ref_count(a_ref), .hit_count(a_hit), .miss_count(a_miss), .cycle_count(a_cyc)
    );

    cache_trace_driver #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .trace_len(trace_len),
        .mem_idx(b_mem_idx), .mem_data(mem_data_b),
        .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .busy(b_busy), .done(b_done), .err(b_err),
        .ref_count(b_ref), .hit_count(b_hit), .miss_count(b_miss), .cycle_count(b_cyc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called right after a falling edge; plays one run, acting as the cache model.
    task automatic run(input int len, input int rdy_lat, input int rsp_lat,
                       input logic [63:0] hmask, input int abort_k, input int mid_start_k);
        int k, wcnt, rcnt;
        bit pending, stalled, finished, aborted, ms_done;
        logic [ADDR_W-1:0] held;
        k = 0; wcnt = 0; rcnt = 0;
        pending = 0; stalled = 0; finished = 0; aborted = 0; ms_done = 0;
        held = '0;
        res_dones = 0; res_bdones = 0; res_done_at = -1;
        start = 1'b1;
        trace_len = len[IDX_W:0];
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0; rsp_valid = 1'b0; rsp_hit = 1'b0; req_ready = 1'b0;
            if (a_done) begin res_dones++; res_done_at = cyc; finished = 1; end
            if (b_done) res_bdones++;
            if (pending) begin
                if (abort_k == k) begin
                    rst_n = 1'b0;
                    aborted = 1; finished = 1;
                end else if (rcnt == rsp_lat) begin
                    rsp_valid = 1'b1; rsp_hit = hmask[k];
                    pending = 0; rcnt = 0; k++;
                end else begin
                    rcnt++;
                end
            end else if (a_req_valid) begin
                if (!stalled) begin
                    chk($sformatf("req_addr[%0d]", k), a_req_addr, rom[k]);
                    held = a_req_addr;
                end else begin
                    chk($sformatf("req_addr_stable[%0d]", k), a_req_addr, held);
                end
                if (wcnt == rdy_lat) begin
                    req_ready = 1'b1; pending = 1; stalled = 0; wcnt = 0;
                end else begin
                    stalled = 1; wcnt++;
                end
            end
            if (k == mid_start_k && !ms_done && !finished) begin
                start = 1'b1; trace_len = '0; ms_done = 1;
            end
        end
        if (aborted) begin
            @(negedge clk);
            chk("abort_busy", a_busy, 0);
            chk("abort_done", a_done, 0);
            chk("abort_no_done_seen", res_dones, 0);
            chk("abort_req_valid", a_req_valid, 0);
            chk("abort_req_addr", a_req_addr, 0);
            chk("abort_mem_idx", a_mem_idx, 0);
            chk("abort_counters", {a_ref, a_hit}, 0);
            chk("abort_miss_cycle", {a_miss, a_cyc}, 0);
            rst_n = 1'b1;
            @(negedge clk);
            $display("run len=%0d aborted during entry %0d", len, abort_k);
        end else begin
            if (!finished) chk("done_timeout", 0, 1);
            @(negedge clk);
            chk("busy_after_finish", a_busy, 0);
            $display("run len=%0d refs=%0d hits=%0d misses=%0d cycles=%0d done_at=%0d",
                     len, a_ref, a_hit, a_miss, a_cyc, res_done_at);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h1000 + 32'(i) * 16;
        rom[0] = 32'h100; rom[1] = 32'h200; rom[2] = 32'h100; rom[3] = 32'h300;
        rst_n = 1'b0; start = 1'b0; trace_len = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_hit = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy_done_err", {a_busy, a_done, a_err, a_req_valid}, 0);
        chk("rst_mem_idx", a_mem_idx, 0);
        chk("rst_req_addr", a_req_addr, 0);
        chk("rst_counters", {a_ref, a_hit, a_miss, a_cyc}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic run: hits on entries 2 and 3
        run(4, 0, 0, 64'hC, -1, -1);
        chk("basic_ref", a_ref, 4);
        chk("basic_hit", a_hit, 2);
        chk("basic_miss", a_miss, 2);
        chk("basic_cycle", a_cyc, 13);
        chk("basic_dones", res_dones, 1);
        chk("basic_done_at", res_done_at, 13);
        chk("basic_err", a_err, 0);
        chk("basic_b_cycle", b_cyc, 13);
        chk("basic_b_dones", res_bdones, 1);

        // spurious response while idle
        rsp_valid = 1'b1; rsp_hit = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0; rsp_hit = 1'b0;
        chk("spurious_err", a_err, 1);
        chk("spurious_counts", {a_ref, a_hit, a_miss, a_cyc}, {32'd4, 32'd2, 32'd2, 32'd13});
        @(negedge clk);

        // backpressure and late response on both references
        run(2, 3, 3, 64'h0, -1, -1);
        chk("bp_cycle", a_cyc, 19);
        chk("bp_done_at", res_done_at, 19);
        chk("bp_counts", {a_ref, a_hit, a_miss}, {32'd2, 32'd0, 32'd2});
        chk("bp_err_cleared", a_err, 0);
        chk("bp_b_cycle_sat", b_cyc, 15);

        // zero-length run
        run(0, 0, 0, 64'h0, -1, -1);
        chk("zero_done_at", res_done_at, 1);
        chk("zero_dones", res_dones, 1);
        chk("zero_cycle", a_cyc, 1);
        chk("zero_counts", {a_ref, a_hit, a_miss}, 0);

        // start pulsed mid-run must be ignored
        run(4, 0, 0, 64'h5, -1, 1);
        chk("midstart_counts", {a_ref, a_hit, a_miss}, {32'd4, 32'd2, 32'd2});
        chk("midstart_cycle", a_cyc, 13);
        chk("midstart_dones", res_dones, 1);
        chk("midstart_err", a_err, 0);

        // saturation on the 4-bit instance
        run(20, 0, 0, 64'hFFFFF, -1, -1);
        chk("sat_a_counts", {a_ref, a_hit, a_miss}, {32'd20, 32'd20, 32'd0});
        chk("sat_a_cycle", a_cyc, 61);
        chk("sat_b_hit", b_hit, 15);
        chk("sat_b_ref", b_ref, 15);
        chk("sat_b_miss", b_miss, 0);
        chk("sat_b_cycle", b_cyc, 15);

        // rerun clears the saturated counters
        run(4, 0, 0, 64'hC, -1, -1);
        chk("rerun_b_counts", {b_ref, b_hit, b_miss, b_cyc}, {4'd4, 4'd2, 4'd2, 4'd13});

        // full-length trace, 2^IDX_W entries
        run(32, 0, 0, 64'h0, -1, -1);
        chk("full_ref", a_ref, 32);
        chk("full_miss", a_miss, 32);
        chk("full_cycle", a_cyc, 97);
        chk("full_done_at", res_done_at, 97);

        // reset during WAIT of entry 5, then a short run afterwards
        run(8, 0, 0, 64'h0, 5, -1);
        run(1, 0, 0, 64'h1, -1, -1);
        chk("post_reset_counts", {a_ref, a_hit, a_miss, a_cyc}, {32'd1, 32'd1, 32'd0, 32'd4});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_trace_driver.md
# cache_trace_driver

Synthesizable, parametrised trace player that replaces the hand-written cache stimulus loop. Reads a trace of reference addresses from an external synchronous ROM, issues each one to the cache under test with a valid/ready request and a variable-latency response handshake, and accumulates saturating reference, hit, miss and cycle statistics. It sits between the trace ROM and the cache model. Software or a bench pulses `start` and reads the counters after `done`.

## Interface
- `ADDR_W`, 32, width of a trace entry / cache reference address
- `IDX_W`, 16, trace ROM index width; max trace length 2^IDX_W entries
- `CNT_W`, 32, width of every statistics counter
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse, begins a run; ignored unless IDLE
- `trace_len` in IDX_W+1: number of entries to play, sampled on accepted `start`
- `mem_idx` out IDX_W: ROM read index
- `mem_data` in ADDR_W: ROM data, valid exactly 1 cycle after `mem_idx`
- `req_valid` out 1: reference request to cache
- `req_addr` out ADDR_W: reference address, stable while `req_valid`
- `req_ready` in 1: cache accepts request when high with `req_valid`
- `rsp_valid` in 1: cache response strobe
- `rsp_hit` in 1: response is a hit, qualified by `rsp_valid`
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse at end of run
- `err` out 1: sticky protocol error flag
- `ref_count`, `hit_count`, `miss_count`, `cycle_count` out CNT_W each: statistics

## Operation
- FSM states: IDLE, FETCH, ISSUE, WAIT, FINISH.
- IDLE: on `start`, latch `trace_len`, clear all four counters and `err`, clear index to 0. Go to FINISH if `trace_len`==0, else FETCH.
- FETCH: drive `mem_idx`=index for one cycle. Next cycle latch `mem_data` into `req_addr`. Go to ISSUE.
- ISSUE: `req_valid`=1. On `req_valid && req_ready`, go to WAIT.
- WAIT: on `rsp_valid`:
  - increment `ref_count`;
  - increment `hit_count` if `rsp_hit`, else `miss_count`;
  - if index+1 == latched length, go to FINISH; otherwise increment index and go to FETCH.
- FINISH: pulse `done`, return to IDLE. Counters hold until the next accepted `start`.
- `cycle_count` increments every cycle `busy`=1, including the FINISH cycle.
- Counters saturate at all-ones. They never wrap.
- `rsp_valid` in any state other than WAIT: ignored for statistics and sets `err`.
- `start` while not IDLE: ignored and has no effect.
- `rsp_valid` in the same cycle as the ISSUE handshake: treated as out-of-state, sets `err`. A response counts only from the cycle after acceptance.
- Index arithmetic is IDX_W+1 bits, so `trace_len`=2^IDX_W plays every entry.
- Invariant: `ref_count` == `hit_count` + `miss_count` while none has saturated.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `err`, `req_valid` = 0;
  - `mem_idx`, `req_addr` = 0;
  - all counters = 0.
- `busy` goes high the cycle after an accepted `start` and low the cycle after FINISH.
- `busy` is combinationally equal to state != IDLE, so it is high during FINISH.
- Minimum per-reference cost is 3 cycles: FETCH, ISSUE with `req_ready`=1, WAIT with immediate `rsp_valid`.
- An N-entry run with zero-wait cache gives `cycle_count` = 3N+1.
- A zero-length run gives `done` 1 cycle after `start` and `cycle_count`=1.
- `req_addr` and `req_valid` are registered. They do not change while `req_valid`=1 and `req_ready`=0.
- Reset asserted mid-run: immediate return to reset values. Nothing is held; no `done` pulse.

## Structure
- Shared package `cache_sim_pkg`:
  - FSM state enum `drv_state_t`;
  - default width constants `CACHE_ADDR_W`=32 and `STAT_CNT_W`=32.
- Sub-module `sat_counter`: parameter W, with `clk`, `rst_n`, `clr`, `inc`, `q`.
  - Saturating increment; `clr` has priority over `inc`.
  - Instantiated four times.
- Trace ROM is external to keep the block synthesizable and trace-agnostic.

## Test plan
- Reset mid-run: assert `rst_n`=0 during WAIT of entry 5 -> all outputs 0 next cycle, no `done`.
- Basic run:
  - ROM {0x100,0x200,0x100,0x300}, `trace_len`=4, cache always ready, hits on entries 2 and 3 (0-based);
  - expect `ref_count`=4, `hit_count`=2, `miss_count`=2, `cycle_count`=13, one `done` pulse, `req_addr` sequence matches ROM.
- Backpressure/latency:
  - `req_ready` low 3 cycles and `rsp_valid` 4 cycles late on every reference, `trace_len`=2;
  - `req_addr` stable throughout, `cycle_count`=2*(3+3+3)+1=19.
- Zero-length run: `trace_len`=0 -> `done` the cycle after `start`, counters 0 except `cycle_count`=1.
- Protocol errors:
  - spurious `rsp_valid` in IDLE -> `err`=1 and counters unchanged;
  - `start` pulsed mid-run -> run completes unaffected.
- Saturation: CNT_W=4, 20 hits -> `hit_count`=15, `ref_count`=15, `miss_count`=0. Rerun with `start` -> counters clear.
